// File: rtl/ric_pkg.sv
// Shared definitions for the response input conditioner.
// Holds the FSM state encoding and the default parameter values.
package ric_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        STUCK   = 2'd2
    } ric_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int STUCK_CYCLES_DEF    = 200;
    localparam int RT_WIDTH_DEF        = 8;

endpackage

// File: rtl/ric_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debounce counter.
// btn_stable changes only after DEBOUNCE_CYCLES differing synchronized samples.
module ric_debounce
    import ric_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_stable
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       stable_q;
    logic       stable_d;

    // Any sample matching the accepted level restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign btn_stable = stable_q;

endmodule

// File: rtl/response_input_conditioner.sv
// Response push-button front end: debounce, press FSM with stuck detection, reaction timer.
// Optional best-time tracking is enabled with RESPONSE_RT_BEST_EN.
module response_input_conditioner
    import ric_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF,
    parameter int RT_WIDTH        = RT_WIDTH_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                btn_raw,
    input  logic                prompt_active,
    output logic                btn_level,
    output logic                press_pulse,
    output logic                stuck_alarm,
    output logic [RT_WIDTH-1:0] reaction_time,
    output logic                rt_valid,
    output logic [RT_WIDTH-1:0] rt_best,
    output ric_state_e          fsm_state
);

    localparam int                HOLD_W    = $clog2(STUCK_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STUCK_CYCLES - 1);

    logic                btn_stable;
    ric_state_e          state_q;
    logic                btn_level_q;
    logic                press_pulse_q;
    logic                stuck_alarm_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [RT_WIDTH-1:0] rt_cnt_q;
    logic [RT_WIDTH-1:0] rt_cnt_d;
    logic [RT_WIDTH-1:0] reaction_time_q;
    logic                rt_valid_q;
    logic                capture;

    ric_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_stable(btn_stable)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            btn_level_q   <= 1'b0;
            press_pulse_q <= 1'b0;
            stuck_alarm_q <= 1'b0;
            hold_q        <= '0;
        end else begin
            press_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_stable) begin
                        state_q       <= PRESSED;
                        btn_level_q   <= 1'b1;
                        press_pulse_q <= 1'b1;
                        hold_q        <= '0;
                    end
                end
                PRESSED: begin
                    if (!btn_stable) begin
                        state_q     <= IDLE;
                        btn_level_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                        if (hold_q == HOLD_LAST) begin
                            state_q       <= STUCK;
                            btn_level_q   <= 1'b0;
                            stuck_alarm_q <= 1'b1;
                        end
                    end
                end
                STUCK: begin
                    // A jammed switch only recovers through a debounced release.
                    if (!btn_stable) begin
                        state_q       <= IDLE;
                        stuck_alarm_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    btn_level_q   <= 1'b0;
                    stuck_alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign capture = (state_q == IDLE) && btn_stable && prompt_active;

    always_comb begin
        rt_cnt_d = rt_cnt_q;
        if (!prompt_active) begin
            rt_cnt_d = '0;
        end else if ((state_q == IDLE) && (rt_cnt_q != {RT_WIDTH{1'b1}})) begin
            rt_cnt_d = rt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rt_cnt_q        <= '0;
            reaction_time_q <= '0;
            rt_valid_q      <= 1'b0;
        end else begin
            rt_cnt_q   <= rt_cnt_d;
            rt_valid_q <= capture;
            if (capture) begin
                reaction_time_q <= rt_cnt_q;
            end
        end
    end

`ifdef RESPONSE_RT_BEST_EN
    logic [RT_WIDTH-1:0] rt_best_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rt_best_q <= '1;
        end else if (rt_valid_q && (reaction_time_q < rt_best_q)) begin
            rt_best_q <= reaction_time_q;
        end
    end

    assign rt_best = rt_best_q;
`else
    assign rt_best = '1;
`endif

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign stuck_alarm   = stuck_alarm_q;
    assign reaction_time = reaction_time_q;
    assign rt_valid      = rt_valid_q;
    assign fsm_state     = state_q;

endmodule
